// File: rtl/goc_pkg.sv
// Shared definitions for the golden/faulty compare sequencer.
package goc_pkg;

    // Sequencer states.
    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LAUNCH = 2'd1,
        WAIT   = 2'd2,
        REPORT = 2'd3
    } state_t;

    // Default widths and bit positions for the FPU golden circuit.
    localparam int GOC_TV_WIDTH  = 70;
    localparam int GOC_RV_WIDTH  = 41;
    localparam int GOC_START_BIT = 69;
    localparam int GOC_READY_BIT = 32;

    // Widest counter the saturating helper supports.
    localparam int SAT_MAX_W = 64;

    // Increment value, holding at the all-ones value of a width-bit counter.
    function automatic logic [SAT_MAX_W-1:0] sat_inc(input logic [SAT_MAX_W-1:0] value,
                                                     input int unsigned           width);
        logic [SAT_MAX_W-1:0] max_val;
        max_val = {SAT_MAX_W{1'b1}} >> (SAT_MAX_W - width);
        return (value == max_val) ? value : value + {{(SAT_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/goc_sat_counter.sv
// Saturating statistics counter with a synchronous clear that wins over increment.
module goc_sat_counter
    import goc_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc_i,
    input  logic                 clr_i,
    output logic [CNT_WIDTH-1:0] cnt_o
);

    logic [CNT_WIDTH-1:0] cnt_q;
    logic [CNT_WIDTH-1:0] cnt_d;

    // Next count: clear first, otherwise saturating increment.
    always_comb begin
        cnt_d = cnt_q;
        if (clr_i) begin
            cnt_d = '0;
        end else if (inc_i) begin
            cnt_d = CNT_WIDTH'(sat_inc(SAT_MAX_W'(cnt_q), CNT_WIDTH));
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt_o = cnt_q;

endmodule

// File: rtl/goc_compare_sequencer.sv
// Drives test vectors into the golden and faulty circuits, waits for golden
// ready (with timeout), compares masked results and keeps statistics.
//
// Handshakes: a transfer happens on a rising clk edge where valid and ready
// are both high; valid never depends combinationally on ready, and the
// offering side holds its payload stable until the transfer.
module goc_compare_sequencer
    import goc_pkg::*;
#(
    parameter int TV_WIDTH    = GOC_TV_WIDTH,
    parameter int RV_WIDTH    = GOC_RV_WIDTH,
    parameter int START_BIT   = GOC_START_BIT,
    parameter int READY_BIT   = GOC_READY_BIT,
    parameter int MIN_LATENCY = 1,
    parameter int TIMEOUT     = 64,
    parameter int CNT_WIDTH   = 32
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 vec_valid_i,
    output logic                 vec_ready_o,
    input  logic [TV_WIDTH-1:0]  vec_data_i,
    input  logic [RV_WIDTH-1:0]  cmp_mask_i,
    output logic [TV_WIDTH-1:0]  tv_o,
    input  logic [RV_WIDTH-1:0]  golden_rv_i,
    input  logic [RV_WIDTH-1:0]  faulty_rv_i,
    output logic                 res_valid_o,
    input  logic                 res_ready_i,
    output logic                 res_mismatch_o,
    output logic                 res_timeout_o,
    output logic [RV_WIDTH-1:0]  res_diff_o,
    input  logic                 clear_i,
    output logic [CNT_WIDTH-1:0] vec_count_o,
    output logic [CNT_WIDTH-1:0] err_count_o,
    output logic [CNT_WIDTH-1:0] tmo_count_o
);

    localparam int WCNT_W = $clog2(TIMEOUT + 1);

    state_t              state_q, state_d;
    logic [TV_WIDTH-1:0] vec_q, vec_d;
    logic [RV_WIDTH-1:0] mask_q, mask_d;
    logic [WCNT_W-1:0]   wcnt_q, wcnt_d;
    logic [RV_WIDTH-1:0] diff_q, diff_d;
    logic                mismatch_q, mismatch_d;
    logic                timeout_q, timeout_d;
    logic                start;
    logic                done;
    logic [RV_WIDTH-1:0] masked_diff;

    assign masked_diff = (golden_rv_i ^ faulty_rv_i) & mask_q;

    // Next-state, result capture and handshake outputs.
    always_comb begin
        state_d     = state_q;
        vec_d       = vec_q;
        mask_d      = mask_q;
        wcnt_d      = wcnt_q;
        diff_d      = diff_q;
        mismatch_d  = mismatch_q;
        timeout_d   = timeout_q;
        vec_ready_o = 1'b0;
        res_valid_o = 1'b0;
        start       = 1'b0;
        done        = 1'b0;
        case (state_q)
            IDLE: begin
                vec_ready_o = 1'b1;
                if (vec_valid_i) begin
                    vec_d   = vec_data_i;
                    mask_d  = cmp_mask_i;
                    state_d = LAUNCH;
                end
            end
            LAUNCH: begin
                start   = 1'b1;
                wcnt_d  = '0;
                state_d = WAIT;
            end
            WAIT: begin
                // Ready seen too soon after launch may be left over from the
                // previous vector, so it is ignored for MIN_LATENCY cycles.
                if ((wcnt_q >= WCNT_W'(MIN_LATENCY)) && golden_rv_i[READY_BIT]) begin
                    diff_d     = masked_diff;
                    mismatch_d = |masked_diff;
                    timeout_d  = 1'b0;
                    state_d    = REPORT;
                end else if (wcnt_q == WCNT_W'(TIMEOUT - 1)) begin
                    diff_d     = '0;
                    mismatch_d = 1'b1;
                    timeout_d  = 1'b1;
                    state_d    = REPORT;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            REPORT: begin
                res_valid_o = 1'b1;
                if (res_ready_i) begin
                    done    = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Vector to both circuits: start bit only high during LAUNCH.
    always_comb begin
        tv_o            = vec_q;
        tv_o[START_BIT] = start;
    end

    // State and datapath registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= IDLE;
            vec_q      <= '0;
            mask_q     <= '0;
            wcnt_q     <= '0;
            diff_q     <= '0;
            mismatch_q <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            vec_q      <= vec_d;
            mask_q     <= mask_d;
            wcnt_q     <= wcnt_d;
            diff_q     <= diff_d;
            mismatch_q <= mismatch_d;
            timeout_q  <= timeout_d;
        end
    end

    assign res_mismatch_o = mismatch_q;
    assign res_timeout_o  = timeout_q;
    assign res_diff_o     = diff_q;

    goc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_vec_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (done),
        .clr_i (clear_i),
        .cnt_o (vec_count_o)
    );

    goc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_err_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (done & mismatch_q),
        .clr_i (clear_i),
        .cnt_o (err_count_o)
    );

    goc_sat_counter #(.CNT_WIDTH(CNT_WIDTH)) u_tmo_cnt (
        .clk   (clk),
        .rst   (rst),
        .inc_i (done & timeout_q),
        .clr_i (clear_i),
        .cnt_o (tmo_count_o)
    );

endmodule

// File: tb/tb_goc_compare_sequencer.sv
// Bench for goc_compare_sequencer: models the golden/faulty circuits,
// predicts each result from the vector's timing/flip/mask description.
module tb_goc_compare_sequencer;

    localparam int TV_W      = 70;
    localparam int RV_W      = 41;
    localparam int START_BIT = 69;
    localparam int READY_BIT = 32;
    localparam int MIN_LAT   = 1;
    localparam int TIMEOUT   = 64;
    localparam int CNT_W     = 32;
    localparam int NEVER     = -1;
    localparam int EXP_W     = 8 + 2 + RV_W;

    typedef struct {
        logic [TV_W-1:0] data;
        logic [RV_W-1:0] mask;
        logic [RV_W-1:0] gold;
        logic [RV_W-1:0] flip;
        int              delay;
        bit              stale;
        int              hold;
        bit              clr;
    } vec_cfg_t;

    logic              clk;
    logic              rst;
    logic              vec_valid_i;
    logic              vec_ready_o;
    logic [TV_W-1:0]   vec_data_i;
    logic [RV_W-1:0]   cmp_mask_i;
    logic [TV_W-1:0]   tv_o;
    logic [RV_W-1:0]   golden_rv_i;
    logic [RV_W-1:0]   faulty_rv_i;
    logic              res_valid_o;
    logic              res_ready_i;
    logic              res_mismatch_o;
    logic              res_timeout_o;
    logic [RV_W-1:0]   res_diff_o;
    logic              clear_i;
    logic [CNT_W-1:0]  vec_count_o;
    logic [CNT_W-1:0]  err_count_o;
    logic [CNT_W-1:0]  tmo_count_o;

    int          n_checks = 0;
    int          n_errors = 0;
    int          cyc = 0;
    int          launch_cyc = 0;
    bit          in_wait = 0;
    bit          mon_busy = 0;
    int unsigned exp_vec = 0;
    int unsigned exp_err = 0;
    int unsigned exp_tmo = 0;

    vec_cfg_t          cfg_q[$];
    vec_cfg_t          ctl_q[$];
    logic [EXP_W-1:0]  exp_q[$];
    logic [RV_W-1:0]   ready_bit;

    goc_compare_sequencer dut (
        .clk            (clk),
        .rst            (rst),
        .vec_valid_i    (vec_valid_i),
        .vec_ready_o    (vec_ready_o),
        .vec_data_i     (vec_data_i),
        .cmp_mask_i     (cmp_mask_i),
        .tv_o           (tv_o),
        .golden_rv_i    (golden_rv_i),
        .faulty_rv_i    (faulty_rv_i),
        .res_valid_o    (res_valid_o),
        .res_ready_i    (res_ready_i),
        .res_mismatch_o (res_mismatch_o),
        .res_timeout_o  (res_timeout_o),
        .res_diff_o     (res_diff_o),
        .clear_i        (clear_i),
        .vec_count_o    (vec_count_o),
        .err_count_o    (err_count_o),
        .tmo_count_o    (tmo_count_o)
    );

    // Clock and cycle counter.
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    always @(posedge clk) cyc = cyc + 1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Expected outcome: {latency from launch to result, timeout, mismatch, diff}.
    function automatic logic [EXP_W-1:0] model_result(input vec_cfg_t c);
        int              cap;
        logic [RV_W-1:0] diff;
        if (c.stale) cap = MIN_LAT;
        else if (c.delay == NEVER) cap = NEVER;
        else cap = (c.delay < MIN_LAT) ? MIN_LAT : c.delay;
        if (cap == NEVER || cap > TIMEOUT - 1)
            return {8'(TIMEOUT - 1 + 2), 1'b1, 1'b1, {RV_W{1'b0}}};
        diff = c.flip & c.mask;
        return {8'(cap + 2), 1'b0, |diff, diff};
    endfunction

    function automatic vec_cfg_t mk(input logic [TV_W-1:0] data, input logic [RV_W-1:0] mask,
                                    input logic [RV_W-1:0] gold, input logic [RV_W-1:0] flip,
                                    input int delay, input bit stale, input int hold, input bit clr);
        vec_cfg_t c;
        c.data = data; c.mask = mask; c.gold = gold; c.flip = flip;
        c.delay = delay; c.stale = stale; c.hold = hold; c.clr = clr;
        return c;
    endfunction

    // Driver: offer one vector and wait for the input handshake.
    task automatic send(input vec_cfg_t c);
        int t;
        cfg_q.push_back(c);
        ctl_q.push_back(c);
        exp_q.push_back(model_result(c));
        vec_data_i  = c.data;
        cmp_mask_i  = c.mask;
        vec_valid_i = 1'b1;
        t = 0;
        while (!vec_ready_o && t < 1000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 1000) check("vec_accept_timeout", 1, 0);
        @(negedge clk);
        vec_valid_i = 1'b0;
        vec_data_i  = TV_W'({$urandom, $urandom, $urandom});
    endtask

    task automatic drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || mon_busy) && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (t >= 3000) check("drain_timeout", exp_q.size(), 0);
    endtask

    // Golden/faulty circuit model: reacts to the start pulse.
    initial begin
        vec_cfg_t        cur;
        int              k;
        bit              first;
        bit              rdy;
        logic [TV_W-1:0] exp_tv;
        golden_rv_i = '0;
        faulty_rv_i = '0;
        k = 0;
        first = 0;
        forever begin
            @(negedge clk);
            if (rst) begin
                in_wait = 0;
            end else if (tv_o[START_BIT]) begin
                if (cfg_q.size() == 0) begin
                    check("unexpected_launch", 1, 0);
                end else begin
                    cur = cfg_q.pop_front();
                    exp_tv = cur.data;
                    exp_tv[START_BIT] = 1'b1;
                    check("tv_launch", tv_o, exp_tv);
                    launch_cyc = cyc;
                    k = 0;
                    in_wait = 1;
                    first = 1;
                    golden_rv_i = cur.stale ? (cur.gold | ready_bit) : (cur.gold & ~ready_bit);
                    faulty_rv_i = golden_rv_i ^ cur.flip;
                end
            end else if (in_wait) begin
                if (first) begin
                    exp_tv = cur.data;
                    exp_tv[START_BIT] = 1'b0;
                    check("tv_wait_start_low", tv_o, exp_tv);
                    first = 0;
                end
                if (res_valid_o) begin
                    in_wait = 0;
                end else begin
                    rdy = cur.stale || (cur.delay != NEVER && k >= cur.delay);
                    golden_rv_i = rdy ? (cur.gold | ready_bit) : (cur.gold & ~ready_bit);
                    faulty_rv_i = golden_rv_i ^ cur.flip;
                    k++;
                end
            end
        end
    end

    // Monitor / scoreboard: compare each presented result, then consume it.
    initial begin
        logic [EXP_W-1:0] e;
        logic [RV_W+1:0]  snap;
        vec_cfg_t         c;
        res_ready_i = 1'b0;
        clear_i     = 1'b0;
        forever begin
            @(negedge clk);
            if (!rst && res_valid_o) begin
                mon_busy = 1;
                if (exp_q.size() == 0 || ctl_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                    c = mk('0, '0, '0, '0, 0, 0, 0, 0);
                    e = '0;
                end else begin
                    e = exp_q.pop_front();
                    c = ctl_q.pop_front();
                    check("res_latency", 8'(cyc - launch_cyc), e[EXP_W-1 -: 8]);
                    check("res_timeout", res_timeout_o, e[RV_W+1]);
                    check("res_mismatch", res_mismatch_o, e[RV_W]);
                    check("res_diff", res_diff_o, e[RV_W-1:0]);
                    check("vec_ready_in_report", vec_ready_o, 0);
                end
                snap = {res_timeout_o, res_mismatch_o, res_diff_o};
                for (int i = 0; i < c.hold; i++) begin
                    @(negedge clk);
                    check("hold_stable", {res_timeout_o, res_mismatch_o, res_diff_o}, snap);
                    check("hold_valid", res_valid_o, 1);
                    check("hold_vec_ready", vec_ready_o, 0);
                end
                res_ready_i = 1'b1;
                clear_i     = c.clr;
                @(negedge clk);
                res_ready_i = 1'b0;
                clear_i     = 1'b0;
                if (c.clr) begin
                    exp_vec = 0; exp_err = 0; exp_tmo = 0;
                end else begin
                    exp_vec++;
                    exp_err += e[RV_W];
                    exp_tmo += e[RV_W+1];
                end
                check("vec_count", vec_count_o, exp_vec);
                check("err_count", err_count_o, exp_err);
                check("tmo_count", tmo_count_o, exp_tmo);
                check("valid_after_ack", res_valid_o, 0);
                check("ready_after_ack", vec_ready_o, 1);
                mon_busy = 0;
            end
        end
    end

    // Main stimulus.
    initial begin
        logic [TV_W-1:0] d;
        logic [RV_W-1:0] g;
        logic [RV_W-1:0] ones;
        logic [RV_W-1:0] one;
        logic [RV_W-1:0] flip;
        logic [RV_W-1:0] mask;
        vec_cfg_t        c;
        int              t;
        ready_bit = '0;
        ready_bit[READY_BIT] = 1'b1;
        ones = '1;
        one  = 1;
        rst = 1'b1;
        vec_valid_i = 1'b0;
        vec_data_i  = '0;
        cmp_mask_i  = '0;
        repeat (3) @(negedge clk);
        check("rst_vec_ready", vec_ready_o, 1);
        check("rst_tv", tv_o, 0);
        check("rst_res_valid", res_valid_o, 0);
        check("rst_outputs", {res_mismatch_o, res_timeout_o, res_diff_o}, 0);
        check("rst_counts", {vec_count_o, err_count_o, tmo_count_o}, 0);
        rst = 1'b0;
        @(negedge clk);

        d = {1'b0, 2'b00, 3'b010, 32'h3F80_0000, 32'h4000_0000};
        g = {8'h00, 1'b1, 32'h4040_0000};
        send(mk(d, ones, g, '0, 3, 0, 0, 0));                       // equal results
        send(mk(d, ones, g, 41'h20, 3, 0, 0, 0));                   // bit 5 flipped
        send(mk(d, ones & ~41'h20, g, 41'h20, 3, 0, 0, 0));         // bit 5 masked off
        send(mk(d, ones, g, '0, NEVER, 0, 0, 0));                   // timeout
        send(mk(d, ones, g, 41'h4, 0, 1, 0, 0));                    // stale ready
        send(mk(d, ones, g, 41'h1, 2, 0, 10, 1));                   // long hold, clear on ack
        drain();

        for (int i = 0; i < 24; i++) begin
            d    = TV_W'({$urandom, $urandom, $urandom});
            g    = RV_W'({$urandom, $urandom});
            flip = ($urandom_range(0, 2) != 0) ? (one << $urandom_range(0, RV_W - 1)) : '0;
            mask = ($urandom_range(0, 1) != 0) ? ones : RV_W'({$urandom, $urandom});
            c = mk(d, mask, g, flip,
                   ($urandom_range(0, 9) == 0) ? NEVER : int'($urandom_range(0, 6)),
                   ($urandom_range(0, 7) == 0), int'($urandom_range(0, 3)),
                   ($urandom_range(0, 11) == 0));
            send(c);
        end
        drain();

        // Reset in the middle of WAIT.
        send(mk(d, ones, g, '0, NEVER, 0, 0, 0));
        t = 0;
        while (!in_wait && t < 100) begin
            @(negedge clk);
            t++;
        end
        if (t >= 100) check("reset_test_launch", in_wait, 1);
        repeat (5) @(negedge clk);
        #2;
        rst = 1'b1;
        #1;
        check("midrst_tv", tv_o, 0);
        check("midrst_vec_ready", vec_ready_o, 1);
        check("midrst_res_valid", res_valid_o, 0);
        check("midrst_counts", {vec_count_o, err_count_o, tmo_count_o}, 0);
        exp_q.delete();
        ctl_q.delete();
        cfg_q.delete();
        exp_vec = 0; exp_err = 0; exp_tmo = 0;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        send(mk(d, ones, g, 41'h100, 2, 0, 1, 0));
        drain();

        repeat (3) @(negedge clk);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
